tube_scan_ctrl: RTL
===================

Name: tube_scan_ctrl

Overview:
- Memory-mapped controller that time-multiplexes the board's 4-digit seven-segment display from the CPU data bus.
- Sits on the CPU's MemBus beside data memory and drives the top-level tube_select / tube_segment pins.
- Software writes a 16-bit hex value and control bits. The block rotates through the digits, decodes each nibble, and swaps in new data only at frame boundaries so the display never tears.

Parameters:
- SCAN_DIV, 100000, sysclk cycles per digit slot (1 ms at 100 MHz); legal range ≥ 2.
- BASE_ADDR, 32'h4000_0010, byte address of DATA register; CTRL register is at BASE_ADDR+4.

Ports:
- sysclk  input  1  system clock, all logic rising-edge.
- reset  input  1  synchronous, active-high reset.
- mem_read  input  1  bus read strobe.
- mem_write  input  1  bus write strobe.
- mem_addr  input  32  bus byte address.
- mem_wdata  input  32  bus write data.
- mem_rdata  output  32  read data, registered.
- tube_select  output  4  one-hot digit enable, active-high; bit0 = rightmost digit.
- tube_segment  output  8  {dp,g,f,e,d,c,b,a}, active-high.

Behaviour:
- Clocking and reset: one clock (sysclk); reset is synchronous and active-high. All registers clear on a reset-high edge.
- Reset values:
  - DATA=16'h0000; CTRL: enable=1, dp_mask=4'h0.
  - Shadow register = 0; prescaler = 0; digit index = 0.
  - mem_rdata=0, tube_select=4'b0000, tube_segment=8'h00.
- Register map:
  - DATA at BASE_ADDR, bits[15:0].
  - CTRL at BASE_ADDR+4: bit0 enable, bits[7:4] dp_mask (bit i lights dp on digit i).
  - Upper bits: ignored on write, read back as 0.
  - Address match is exact; other addresses are ignored. Write takes effect on the clock edge with mem_write=1.
- Reads: mem_rdata = register contents one cycle after mem_read with a matching address; otherwise 0 on the next cycle. A read and a write to the same register in the same cycle return the old value.
- Prescaler: counts 0..SCAN_DIV-1 while enabled. Terminal count produces a 1-cycle tick and wraps to 0.
- Digit FSM: states D0→D1→D2→D3→D0, advancing on tick.
  - Frame boundary = tick while in D3.
  - On the frame boundary the shadow register loads DATA and dp_mask.
  - A write on the same edge as the boundary is captured into the shadow register.
- Outputs are registered: each cycle, tube_select = one-hot(index) and tube_segment = decode(shadow nibble[index]) | dp.
  - Outputs lag the index by 1 cycle; first valid output is the cycle after reset deasserts (select 4'b0001, segment 8'h3F).
- Hex decode values:
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07.
  - 8:7F, 9:6F, A:77, b:7C, C:39, d:5E, E:79, F:71.
- Enable=0:
  - Prescaler and index are forced to 0.
  - Shadow register loads DATA and dp_mask every cycle, so the next enable shows new data immediately.
  - Outputs are forced to 0 on the next cycle.
- Re-enable: the scan restarts at D0 with prescaler 0.
- Reset mid-frame: reset wins over all other activity. Scan restarts at D0 and shadow = 0.

Optional Feature:
- Macro: TUBE_LZ_BLANK_EN (leading-zero blanking).
- Defined:
  - A digit i>0 is blanked (segment a–g = 0, select still asserted) when shadow nibbles i..3 are all zero.
  - Digit 0 is never blanked. The dp bit still honours dp_mask.
- Undefined: all four digits are always decoded.

Test Plan:
All scenarios use SCAN_DIV=4.
- Reset 2 cycles then release, no writes → cycle after release: select 4'b0001, segment 8'h3F. select rotates 0001→0010→0100→1000 every 4 cycles, segment stays 8'h3F.
- Write DATA=32'h0000_12AF mid-frame → digits unchanged until frame boundary. Next frame shows segments 71,77,5B,06 on select 0001,0010,0100,1000.
- Write CTRL=32'h51 (enable, dp on digits 0 and 2) with DATA=16'h1234 → after the boundary, segment for digit 0 = 8'hE6 and for digit 2 = 8'hDB.
- Write CTRL=0, then read BASE_ADDR+4 → one cycle later outputs = 0 and mem_rdata = 0. Write CTRL=1 → next cycle select 4'b0001 showing current DATA.
- Read BASE_ADDR after writing 32'hDEAD_BEEF; read unmapped 32'h4000_0000 → mem_rdata=32'h0000_BEEF, then 0. Display is unaffected by the unmapped access.
- With TUBE_LZ_BLANK_EN, DATA=16'h0050 → digits 3 and 2 have segment 8'h00, digit 1 = 8'h6D, digit 0 = 8'h3F. Repeat with DATA=0: only digit 0 is lit (3F).

Source files
------------

// File: rtl/tube_scan_ctrl.sv
// Memory-mapped 4-digit seven-segment scan controller with frame-synchronous data swap.
// Optional leading-zero blanking is enabled by defining TUBE_LZ_BLANK_EN.
module tube_scan_ctrl #(
   parameter int          SCAN_DIV  = 100000,
   parameter logic [31:0] BASE_ADDR = 32'h4000_0010
) (
   input  logic        sysclk,
   input  logic        reset,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic [31:0] mem_rdata,
   output logic [3:0]  tube_select,
   output logic [7:0]  tube_segment
);

   localparam int                PRE_W     = $clog2(SCAN_DIV);
   localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(SCAN_DIV - 1);
   localparam logic [31:0]       CTRL_ADDR = BASE_ADDR + 32'd4;

   typedef enum logic [1:0] {D0, D1, D2, D3} digit_t;

   logic [15:0]      data_q;
   logic             enable_q;
   logic [3:0]       dp_mask_q;
   logic [15:0]      shadow_data;
   logic [3:0]       shadow_dp;
   logic [PRE_W-1:0] prescaler;
   digit_t           digit;

   logic        wr_data, wr_ctrl, rd_data, rd_ctrl;
   logic        tick, frame_end;
   logic [15:0] data_next;
   logic [3:0]  dp_next;
   logic [3:0]  nibble;
   logic        dp_bit;
   logic        blank;
   logic [6:0]  seg_bits;
   logic        unused_wdata;

   assign wr_data = mem_write && (mem_addr == BASE_ADDR);
   assign wr_ctrl = mem_write && (mem_addr == CTRL_ADDR);
   assign rd_data = mem_read  && (mem_addr == BASE_ADDR);
   assign rd_ctrl = mem_read  && (mem_addr == CTRL_ADDR);

   // Forwarding lets a write landing on the frame boundary reach the shadow copy.
   assign data_next = wr_data ? mem_wdata[15:0] : data_q;
   assign dp_next   = wr_ctrl ? mem_wdata[7:4]  : dp_mask_q;

   assign tick      = enable_q && (prescaler == PRE_LAST);
   assign frame_end = tick && (digit == D3);

   assign unused_wdata = ^{mem_wdata[31:16], mem_wdata[3:1]};

   function automatic logic [6:0] hex_seg(input logic [3:0] n);
      case (n)
         4'h0:    hex_seg = 7'h3F;
         4'h1:    hex_seg = 7'h06;
         4'h2:    hex_seg = 7'h5B;
         4'h3:    hex_seg = 7'h4F;
         4'h4:    hex_seg = 7'h66;
         4'h5:    hex_seg = 7'h6D;
         4'h6:    hex_seg = 7'h7D;
         4'h7:    hex_seg = 7'h07;
         4'h8:    hex_seg = 7'h7F;
         4'h9:    hex_seg = 7'h6F;
         4'hA:    hex_seg = 7'h77;
         4'hB:    hex_seg = 7'h7C;
         4'hC:    hex_seg = 7'h39;
         4'hD:    hex_seg = 7'h5E;
         4'hE:    hex_seg = 7'h79;
         default: hex_seg = 7'h71;
      endcase
   endfunction

   always_comb begin
      nibble = shadow_data[3:0];
      dp_bit = shadow_dp[0];
      blank  = 1'b0;
      case (digit)
         D0: begin
            nibble = shadow_data[3:0];
            dp_bit = shadow_dp[0];
         end
         D1: begin
            nibble = shadow_data[7:4];
            dp_bit = shadow_dp[1];
`ifdef TUBE_LZ_BLANK_EN
            blank  = (shadow_data[15:4] == 12'h000);
`endif
         end
         D2: begin
            nibble = shadow_data[11:8];
            dp_bit = shadow_dp[2];
`ifdef TUBE_LZ_BLANK_EN
            blank  = (shadow_data[15:8] == 8'h00);
`endif
         end
         default: begin
            nibble = shadow_data[15:12];
            dp_bit = shadow_dp[3];
`ifdef TUBE_LZ_BLANK_EN
            blank  = (shadow_data[15:12] == 4'h0);
`endif
         end
      endcase
      seg_bits = blank ? 7'h00 : hex_seg(nibble);
   end

   // Software-visible registers and the registered read port; reads see pre-write contents.
   always_ff @(posedge sysclk) begin
      if (reset) begin
         data_q    <= 16'h0000;
         enable_q  <= 1'b1;
         dp_mask_q <= 4'h0;
         mem_rdata <= 32'h0000_0000;
      end else begin
         if (wr_data) begin
            data_q <= mem_wdata[15:0];
         end
         if (wr_ctrl) begin
            enable_q  <= mem_wdata[0];
            dp_mask_q <= mem_wdata[7:4];
         end
         if (rd_data) begin
            mem_rdata <= {16'h0000, data_q};
         end else if (rd_ctrl) begin
            mem_rdata <= {24'h00_0000, dp_mask_q, 3'b000, enable_q};
         end else begin
            mem_rdata <= 32'h0000_0000;
         end
      end
   end

   // Scan engine: while disabled the shadow tracks live data so re-enable shows it at once.
   always_ff @(posedge sysclk) begin
      if (reset) begin
         prescaler    <= '0;
         digit        <= D0;
         shadow_data  <= 16'h0000;
         shadow_dp    <= 4'h0;
         tube_select  <= 4'b0000;
         tube_segment <= 8'h00;
      end else begin
         if (!enable_q) begin
            prescaler <= '0;
            digit     <= D0;
         end else if (tick) begin
            prescaler <= '0;
            case (digit)
               D0:      digit <= D1;
               D1:      digit <= D2;
               D2:      digit <= D3;
               default: digit <= D0;
            endcase
         end else begin
            prescaler <= prescaler + PRE_W'(1);
         end

         if (!enable_q || frame_end) begin
            shadow_data <= data_next;
            shadow_dp   <= dp_next;
         end

         if (enable_q) begin
            tube_select  <= 4'b0001 << digit;
            tube_segment <= {dp_bit, seg_bits};
         end else begin
            tube_select  <= 4'b0000;
            tube_segment <= 8'h00;
         end
      end
   end

endmodule
